mac_accum_array: RTL and testbench

- Parametrised successor to the per-tile sum/mult/xor/accumulate element.
- NUM_CH independent lanes share one valid/ready handshake.
- Each lane pipelines a per-sample operation selected by i_mode, then accumulates ACC_LEN accepted samples into a frame result.
- Sits between the row/column operand distribution and the reduction/readout logic; replaces free-running accumulators that had no framing or backpressure.

---
 rtl/mac_accum_array.sv | 153 +++++++++++++++
 tb/tb_mac_accum_array.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_array.sv
// NUM_CH-lane framed multiply/add/xor/subtract accumulator with a shared valid/ready handshake.
// Define MAC_ACCUM_SAT_EN for saturating accumulation and the per-lane o_sat flags.
`timescale 1ns/1ps
module mac_accum_array #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ACC_LEN = 8
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [NUM_CH*WIDTH-1:0]        i_a,
  input  logic [NUM_CH*WIDTH-1:0]        i_b,
  input  logic [1:0]                     i_mode,
  input  logic                           i_clear,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [NUM_CH*WIDTH-1:0]        o_acc,
`ifdef MAC_ACCUM_SAT_EN
  output logic [NUM_CH-1:0]              o_sat,
`endif
  output logic [$clog2(ACC_LEN+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(ACC_LEN + 1);

  typedef enum logic [1:0] {StAccum, StDrain, StHold} state_e;

  state_e          state_q;
  logic            ready_q, valid_q;
  logic            s1_valid_q, s2_valid_q;
  logic [1:0]      s1_mode_q;
  logic [CW-1:0]   count_q;

  logic accept, last_accept, frame_done, acc_clr;

  assign accept      = i_valid && ready_q && !i_clear;
  assign last_accept = accept && (count_q == CW'(ACC_LEN - 1));
  assign frame_done  = (state_q == StHold) && i_ready && !i_clear;
  assign acc_clr     = i_reset || i_clear || frame_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StAccum;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_mode_q  <= 2'b00;
      count_q    <= '0;
    end else if (i_clear) begin
      state_q    <= StAccum;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      if (accept) s1_mode_q <= i_mode;
      case (state_q)
        StAccum: begin
          ready_q <= 1'b1;
          if (accept) count_q <= count_q + 1'b1;
          if (last_accept) begin
            state_q <= StDrain;
            ready_q <= 1'b0;
          end
        end
        // Last sample sits in S2 with S1 empty: it lands in the accumulator on this edge.
        StDrain: begin
          if (s2_valid_q && !s1_valid_q) begin
            state_q <= StHold;
            valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (i_ready) begin
            state_q <= StAccum;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            count_q <= '0;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_count = count_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] sum_q, diff_q, prod_q, res_q, acc_q;

    assign a = i_a[k*WIDTH +: WIDTH];
    assign b = i_b[k*WIDTH +: WIDTH];

    always_ff @(posedge i_clk) begin
      if (accept) begin
        sum_q  <= a + b;
        diff_q <= a - b;
        prod_q <= a * b;
      end
      if (s1_valid_q) begin
        unique case (s1_mode_q)
          2'b00: res_q <= sum_q;
          2'b01: res_q <= prod_q;
          2'b10: res_q <= sum_q ^ prod_q;
          2'b11: res_q <= diff_q;
        endcase
      end
    end

`ifdef MAC_ACCUM_SAT_EN
    logic             sat_q;
    logic [WIDTH:0]   acc_ext;

    assign acc_ext = {1'b0, acc_q} + {1'b0, res_q};

    always_ff @(posedge i_clk) begin
      if (acc_clr) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end else if (s2_valid_q) begin
        if (acc_ext[WIDTH]) begin
          acc_q <= {WIDTH{1'b1}};
          sat_q <= 1'b1;
        end else begin
          acc_q <= acc_ext[WIDTH-1:0];
        end
      end
    end

    assign o_sat[k] = sat_q;
`else
    always_ff @(posedge i_clk) begin
      if (acc_clr) begin
        acc_q <= '0;
      end else if (s2_valid_q) begin
        acc_q <= acc_q + res_q;
      end
    end
`endif

    assign o_acc[k*WIDTH +: WIDTH] = acc_q;
  end

endmodule

// File: tb/tb_mac_accum_array.sv
// Scoreboard bench for mac_accum_array: frames push expected results, a negedge monitor checks them.
// Honours MAC_ACCUM_SAT_EN to check the saturating variant and o_sat.
`timescale 1ns/1ps
module tb_mac_accum_array;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int L  = 8;
  localparam int CW = $clog2(L + 1);

  typedef logic [N*W-1:0] vec_t;
  typedef struct packed {
    vec_t          acc;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready, clr, out_valid, ds_ready;
  logic [1:0]    mode;
  vec_t          a, b, acc;
  logic [CW-1:0] cnt;
`ifdef MAC_ACCUM_SAT_EN
  logic [N-1:0]  sat;
`endif

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;

  mac_accum_array #(.WIDTH(W), .NUM_CH(N), .ACC_LEN(L)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_a     (a),
    .i_b     (b),
    .i_mode  (mode),
    .i_clear (clr),
    .o_valid (out_valid),
    .i_ready (ds_ready),
    .o_acc   (acc),
`ifdef MAC_ACCUM_SAT_EN
    .o_sat   (sat),
`endif
    .o_count (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  function automatic vec_t lanes(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Result monitor: compares every downstream handshake against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !clr && out_valid && ds_ready) begin
      if (sb.size() == 0) begin
        chkb("unexpected_result", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("frame_acc", acc, e.acc);
        chk("frame_count", vec_t'(cnt), vec_t'(e.cnt));
`ifdef MAC_ACCUM_SAT_EN
        chk("frame_sat", vec_t'(sat), vec_t'(e.sat));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input vec_t va, input vec_t vb);
    int g;
    g = 0;
    in_valid = 1'b1;
    mode = m;
    a = va;
    b = vb;
    @(negedge clk);
    while (!out_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!out_ready) chkb("accept_timeout", 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  // Edges from the last accept edge until o_valid is seen; the frame result needs two more.
  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency_edges", vec_t'(n), vec_t'(2));
    chk("hold_count", vec_t'(cnt), vec_t'(L));
  endtask

  task automatic post_handshake(input string tag);
    tick();
    chkb({tag, "_valid_low"}, out_valid, 1'b0);
    chk({tag, "_acc_zero"}, acc, '0);
    chk({tag, "_count_zero"}, vec_t'(cnt), '0);
    chkb({tag, "_ready_high"}, out_ready, 1'b1);
  endtask

  task automatic frame_sum();
    for (int s = 0; s < L; s++) send(2'b00, lanes(1, 2, 3, 4), lanes(2, 2, 2, 2));
  endtask

  task automatic frame_mixed();
    send(2'b01, lanes(3, 5, 0, 0), lanes(5, 3, 0, 0));
    send(2'b10, lanes(3, 5, 0, 0), lanes(5, 3, 0, 0));
    send(2'b11, lanes(2, 5, 0, 0), lanes(7, 3, 0, 0));
    send(2'b00, lanes(1, 5, 0, 0), lanes(1, 3, 0, 0));
    for (int s = 0; s < 4; s++) send(2'b00, '0, '0);
  endtask

  task automatic frame_wrap();
    send(2'b00, lanes(32'hFFFF_FFF0, 1, 0, 0), lanes(32'h10, 1, 0, 0));
    send(2'b00, lanes(32'hFFFF_FFFF, 1, 0, 0), lanes(0, 1, 0, 0));
    send(2'b00, lanes(32'hFFFF_FFFF, 1, 0, 0), lanes(0, 1, 0, 0));
    for (int s = 0; s < 5; s++) send(2'b00, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; ds_ready = 1'b1;
    mode = 2'b00; a = '0; b = '0;

    // Reset values, then o_ready one edge after release.
    repeat (3) tick();
    chkb("rst_ready", out_ready, 1'b0);
    chkb("rst_valid", out_valid, 1'b0);
    chk("rst_acc", acc, '0);
    chk("rst_count", vec_t'(cnt), '0);
    rst = 1'b0;
    chkb("release_ready_before_edge", out_ready, 1'b0);
    tick();
    chkb("release_ready_after_edge", out_ready, 1'b1);

    // Basic sum frame: lane k = 8*(k+3).
    sb.push_back('{acc: lanes(24, 32, 40, 48), cnt: CW'(L), sat: '0});
    frame_sum();
    wait_valid();
    post_handshake("sum");

    // Mixed modes: lane0 15+7+(-5)+2 = 0x13, lane1 15+7+2+8 = 0x20.
    sb.push_back('{acc: lanes(32'h13, 32'h20, 0, 0), cnt: CW'(L), sat: '0});
    frame_mixed();
    wait_valid();
    post_handshake("mixed");

    // Backpressure in HOLD with ignored i_valid pulses.
    ds_ready = 1'b0;
    sb.push_back('{acc: lanes(24, 32, 40, 48), cnt: CW'(L), sat: '0});
    frame_sum();
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = vec_t'($urandom);
      b = vec_t'($urandom);
      tick();
      chkb("bp_valid", out_valid, 1'b1);
      chk("bp_acc", acc, lanes(24, 32, 40, 48));
      chkb("bp_ready", out_ready, 1'b0);
    end
    in_valid = 1'b0;
    ds_ready = 1'b1;
    post_handshake("bp");
    sb.push_back('{acc: lanes(32'h13, 32'h20, 0, 0), cnt: CW'(L), sat: '0});
    frame_mixed();
    wait_valid();
    post_handshake("after_bp");

    // Clear after 3 accepts with S1/S2 occupied; the sample in the clear cycle is dropped.
    for (int s = 0; s < 3; s++) send(2'b00, lanes(1, 2, 3, 4), lanes(2, 2, 2, 2));
    clr = 1'b1;
    in_valid = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_count", vec_t'(cnt), '0);
    chk("clr_acc", acc, '0);
    chkb("clr_valid", out_valid, 1'b0);
    chkb("clr_ready", out_ready, 1'b1);
    repeat (3) tick();
    chk("clr_acc_settled", acc, '0);
    sb.push_back('{acc: lanes(24, 32, 40, 48), cnt: CW'(L), sat: '0});
    frame_sum();
    wait_valid();
    post_handshake("after_clr");

    // Clear in HOLD together with i_ready: result is discarded, no handshake.
    ds_ready = 1'b0;
    frame_sum();
    wait_valid();
    clr = 1'b1;
    ds_ready = 1'b1;
    tick();
    clr = 1'b0;
    chkb("hold_clr_valid", out_valid, 1'b0);
    chk("hold_clr_acc", acc, '0);
    chk("hold_clr_count", vec_t'(cnt), '0);
    chkb("hold_clr_ready", out_ready, 1'b1);

    // Reset while draining.
    frame_sum();
    rst = 1'b1;
    tick();
    chkb("drain_rst_valid", out_valid, 1'b0);
    chk("drain_rst_acc", acc, '0);
    chk("drain_rst_count", vec_t'(cnt), '0);
    chkb("drain_rst_ready", out_ready, 1'b0);
    tick();
    rst = 1'b0;
    chkb("drain_rel_ready_before_edge", out_ready, 1'b0);
    tick();
    chkb("drain_rel_ready", out_ready, 1'b1);

    // Wrap / saturate on lane 0; lane 1 stays small and never clamps.
`ifdef MAC_ACCUM_SAT_EN
    sb.push_back('{acc: lanes(32'hFFFF_FFFF, 6, 0, 0), cnt: CW'(L), sat: 4'b0001});
`else
    sb.push_back('{acc: lanes(32'hFFFF_FFFE, 6, 0, 0), cnt: CW'(L), sat: '0});
`endif
    frame_wrap();
    wait_valid();
    post_handshake("wrap");

    repeat (3) tick();
    chk("scoreboard_drained", vec_t'(sb.size()), '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
